chimera_cluster_pwr_seq: RTL

//  Per-cluster clock-gate and AXI-isolation sequencer. Sits between the TopLevelCfgRegs register file
//  (0x3000_1000 region) and the ExtClusters cluster wrappers, and translates each static enable bit into
//  an ordered handshake: isolate, then gate; or ungate, settle, then de-isolate.

---
 rtl/chimera_pkg.sv | 51 +++++
 rtl/chimera_cluster_pwr_seq_fsm.sv | 128 ++++++++++++
 rtl/chimera_cluster_pwr_seq.sv | 61 ++++++
 3 files changed

// File: rtl/chimera_pkg.sv
// ----------------------------------------------------------------------------
// chimera_pkg
// Shared types and constants for the Chimera SoC top level. This slice holds the
// items used by the per-cluster power sequencer:
//   ExtClusters       number of external cluster wrappers
//   PwrSettleCycles   default clock settle time before isolation is released
//   PwrTimeoutCycles  default isolate/de-isolate handshake timeout
//   pwr_state_e       per-cluster sequencer state
//   pwr_outs()        output pattern {clk_en, isolate, busy} for a given state
//   pwr_cnt_width()   width of the sequencer's cycle counter
// ----------------------------------------------------------------------------
package chimera_pkg;

    localparam int unsigned ExtClusters      = 5;
    localparam int unsigned PwrSettleCycles  = 4;
    localparam int unsigned PwrTimeoutCycles = 1024;

    typedef enum logic [2:0] {
        PWR_OFF    = 3'd0,
        PWR_UNGATE = 3'd1,
        PWR_DEISO  = 3'd2,
        PWR_ON     = 3'd3,
        PWR_ISO    = 3'd4,
        PWR_GATE   = 3'd5
    } pwr_state_e;

    // {clk_en, isolate, busy} driven while the sequencer sits in a state.
    function automatic logic [2:0] pwr_outs(input pwr_state_e state);
        logic [2:0] outs;
        outs = 3'b010;
        case (state)
            PWR_OFF:    outs = 3'b010;
            PWR_UNGATE: outs = 3'b111;
            PWR_DEISO:  outs = 3'b101;
            PWR_ON:     outs = 3'b100;
            PWR_ISO:    outs = 3'b111;
            PWR_GATE:   outs = 3'b011;
            default:    outs = 3'b010;
        endcase
        return outs;
    endfunction

    // Counter only ever holds values up to max(settle, timeout) - 1; keep at least 1 bit.
    function automatic int unsigned pwr_cnt_width(input int unsigned settle,
                                                  input int unsigned timeout);
        int unsigned longest;
        longest = (settle > timeout) ? settle : timeout;
        return ($clog2(longest) < 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/chimera_cluster_pwr_seq_fsm.sv
// ----------------------------------------------------------------------------
// chimera_cluster_pwr_fsm
// Single-cluster clock-gate / AXI-isolation sequencer: one FSM, one down-counter
// and a sticky timeout flag. Power-down is isolate -> wait for ack -> gate;
// power-up is ungate -> settle -> de-isolate -> wait for release.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   cluster_en_i   requested state (1 = running), sampled only in OFF and ON
//   err_clr_i      single-cycle pulse clearing err_o
//   isolated_i     isolate-module status (1 = quiesced and isolated)
//   isolate_o      isolate request            (registered)
//   clk_en_o       clock-gate enable          (registered)
//   busy_o         in a transitional state    (registered)
//   err_o          sticky handshake timeout   (registered)
// ----------------------------------------------------------------------------
module chimera_cluster_pwr_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned SettleCycles  = PwrSettleCycles,
    parameter int unsigned TimeoutCycles = PwrTimeoutCycles,
    parameter logic        ResetOn       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cluster_en_i,
    input  logic err_clr_i,
    input  logic isolated_i,
    output logic isolate_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic err_o
);

    localparam int unsigned CntW = pwr_cnt_width(SettleCycles, TimeoutCycles);
    localparam logic [CntW-1:0] SettleLoad  = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);
    localparam pwr_state_e      RstState    = ResetOn ? PWR_ON : PWR_OFF;

    pwr_state_e      state;
    logic [CntW-1:0] cnt;
    logic            cnt_zero;
    logic            timeout;

    assign cnt_zero = (cnt == '0);

    // A handshake times out when the counter is exhausted and the isolate module
    // still reports the old status.
    assign timeout = cnt_zero &&
                     (((state == PWR_DEISO) && isolated_i) ||
                      ((state == PWR_ISO)   && !isolated_i));

    // Outputs are loaded together with the state they belong to, so they change
    // on the same edge as the state transition. The counter is only decremented
    // when non-zero, so it never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= RstState;
            cnt       <= '0;
            clk_en_o  <= ResetOn;
            isolate_o <= ~ResetOn;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            // Set wins over a simultaneous clear.
            err_o <= timeout | (err_o & ~err_clr_i);

            case (state)
                PWR_OFF: begin
                    if (cluster_en_i) begin
                        state <= PWR_UNGATE;
                        cnt   <= SettleLoad;
                        {clk_en_o, isolate_o, busy_o} <= pwr_outs(PWR_UNGATE);
                    end
                end
                PWR_UNGATE: begin
                    if (cnt_zero) begin
                        state <= PWR_DEISO;
                        cnt   <= TimeoutLoad;
                        {clk_en_o, isolate_o, busy_o} <= pwr_outs(PWR_DEISO);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PWR_DEISO: begin
                    // Either the isolation is released or we give up and run anyway.
                    if (!isolated_i || cnt_zero) begin
                        state <= PWR_ON;
                        cnt   <= '0;
                        {clk_en_o, isolate_o, busy_o} <= pwr_outs(PWR_ON);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PWR_ON: begin
                    if (!cluster_en_i) begin
                        state <= PWR_ISO;
                        cnt   <= TimeoutLoad;
                        {clk_en_o, isolate_o, busy_o} <= pwr_outs(PWR_ISO);
                    end
                end
                PWR_ISO: begin
                    if (isolated_i) begin
                        state <= PWR_GATE;
                        cnt   <= '0;
                        {clk_en_o, isolate_o, busy_o} <= pwr_outs(PWR_GATE);
                    end else if (cnt_zero) begin
                        // Never gate with the handshake open: back out through DEISO.
                        state <= PWR_DEISO;
                        cnt   <= TimeoutLoad;
                        {clk_en_o, isolate_o, busy_o} <= pwr_outs(PWR_DEISO);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PWR_GATE: begin
                    state <= PWR_OFF;
                    {clk_en_o, isolate_o, busy_o} <= pwr_outs(PWR_OFF);
                end
                default: begin
                    state <= RstState;
                    cnt   <= '0;
                    {clk_en_o, isolate_o, busy_o} <= pwr_outs(RstState);
                end
            endcase
        end
    end

endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// ----------------------------------------------------------------------------
// chimera_cluster_pwr_seq
// Per-cluster clock-gate and AXI-isolation sequencer between the top-level
// configuration registers and the external cluster wrappers. Each cluster has
// an independent sequencer; this level only replicates them and checks the
// parameters.
// Ports (all vectors NumClusters wide, bit i belongs to cluster i):
//   clk_i, rst_ni  SoC clock, asynchronous active-low reset
//   cluster_en_i   requested state from cfg regs (1 = running)
//   err_clr_i      single-cycle pulse clearing err_o[i]
//   isolate_o      request to the AXI isolate module
//   isolated_i     isolate-module status (1 = quiesced and isolated)
//   clk_en_o       cluster clock-gate enable
//   busy_o         cluster in a transitional state
//   err_o          sticky handshake-timeout flag
// ----------------------------------------------------------------------------
module chimera_cluster_pwr_seq
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters   = ExtClusters,
    parameter int unsigned SettleCycles  = PwrSettleCycles,
    parameter int unsigned TimeoutCycles = PwrTimeoutCycles,
    parameter logic        ResetOn       = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumClusters-1:0] cluster_en_i,
    input  logic [NumClusters-1:0] err_clr_i,
    output logic [NumClusters-1:0] isolate_o,
    input  logic [NumClusters-1:0] isolated_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] err_o
);

    if (SettleCycles < 1) begin : g_bad_settle
        $error("chimera_cluster_pwr_seq: SettleCycles must be >= 1");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("chimera_cluster_pwr_seq: TimeoutCycles must be >= 2");
    end

    for (genvar i = 0; i < NumClusters; i++) begin : g_cluster
        chimera_cluster_pwr_fsm #(
            .SettleCycles  (SettleCycles),
            .TimeoutCycles (TimeoutCycles),
            .ResetOn       (ResetOn)
        ) u_fsm (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .cluster_en_i (cluster_en_i[i]),
            .err_clr_i    (err_clr_i[i]),
            .isolated_i   (isolated_i[i]),
            .isolate_o    (isolate_o[i]),
            .clk_en_o     (clk_en_o[i]),
            .busy_o       (busy_o[i]),
            .err_o        (err_o[i])
        );
    end

endmodule
